// File: rtl/alt_vipitc130_is2vid_ctrl_master_if.sv
// ---------------------------------------------------------------------------
// alt_vipitc130_is2vid_ctrl_master_if
// Avalon-MM bundle between the IS2Vid control master and the CVO control
// slave port.
//
// Handshake: the master presents one command (av_read or av_write, never
// both) with address/data and holds all of it stable while av_waitrequest=1.
// The command is accepted in the first cycle with av_waitrequest=0.
// av_readdata is valid in that accept cycle (zero read latency).
//
// Signals:
//   av_address     master->slave  8   word address
//   av_read        master->slave  1   read request
//   av_write       master->slave  1   write request
//   av_writedata   master->slave  16  write data
//   av_readdata    slave->master  16  read data
//   av_waitrequest slave->master  1   stall
// ---------------------------------------------------------------------------
interface alt_vipitc130_is2vid_ctrl_master_if;
    logic [7:0]  av_address;
    logic        av_read;
    logic        av_write;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        av_waitrequest;

    modport master (
        output av_address,
        output av_read,
        output av_write,
        output av_writedata,
        input  av_readdata,
        input  av_waitrequest
    );

    modport slave (
        input  av_address,
        input  av_read,
        input  av_write,
        input  av_writedata,
        output av_readdata,
        output av_waitrequest
    );
endinterface

// File: rtl/alt_vipitc130_is2vid_ctrl_master.sv
// ---------------------------------------------------------------------------
// alt_vipitc130_is2vid_ctrl_master
// Avalon-MM master that programs and supervises the IS2Vid control slave.
// On start it disables the output, loads TBL_DEPTH mode registers from an
// external table, then re-enables with interrupts. In RUN it services
// status interrupts, polls status periodically, clears underflow and
// reports mode/genlock state.
//
// Build option: define ITC_CTRL_GENLOCK_EN to enable genlock support
// (genlock_mode drives the enable word, both irq enables set, ICLR clears
// bits 2:1, genlocked output live). Undefined: genlock bits 0, only the
// status irq enabled, ICLR clears bit 1, genlocked tied to 0.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start, stop       command pulses (start honoured in IDLE/RUN, stop in RUN)
//   tbl_index/entry   table lookup: entry = {addr[23:16], data[15:0]}
//   genlock_mode      genlock_enable field value (genlock build only)
//   av                Avalon-MM master (see interface file)
//   irq               status_update_int level from the slave
//   busy              state is neither IDLE nor RUN
//   running           RUN or one of its service substates
//   error             sticky write-stall timeout, cleared on start
//   underflow_count   saturating count of underflow clears
//   mode_match        last value read from slave address 4
//   genlocked         last genlocked bit (addr1 bit3)
//   state_dbg         current FSM state encoding
// ---------------------------------------------------------------------------
module alt_vipitc130_is2vid_ctrl_master #(
    parameter int TBL_DEPTH   = 16,
    parameter int POLL_CYCLES = 1024,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [7:0]  tbl_index,
    input  logic [23:0] tbl_entry,
    input  logic [1:0]  genlock_mode,
    alt_vipitc130_is2vid_ctrl_master_if.master av,
    input  logic        irq,
    output logic        busy,
    output logic        running,
    output logic        error,
    output logic [15:0] underflow_count,
    output logic [15:0] mode_match,
    output logic        genlocked,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_DIS  = 4'd1,
        S_LOAD = 4'd2,
        S_ENA  = 4'd3,
        S_RUN  = 4'd4,
        S_DIS0 = 4'd5,
        S_IRD  = 4'd6,
        S_MRD  = 4'd7,
        S_ICLR = 4'd8,
        S_SRD  = 4'd9,
        S_UCLR = 4'd10
    } state_t;

    localparam int PW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(TIMEOUT);
    localparam logic [SW-1:0] STALL_TRIP = SW'(TIMEOUT - 1);
    localparam logic [7:0]    IDX_LAST   = 8'(TBL_DEPTH - 1);

`ifdef ITC_CTRL_GENLOCK_EN
    localparam logic [1:0]  IRQ_EN     = 2'b11;
    localparam logic [15:0] ICLR_MASK  = 16'h0006;
    localparam bit          GENLOCK_EN = 1'b1;
    logic [1:0] genlock_bits;
    assign genlock_bits = genlock_mode;
`else
    localparam logic [1:0]  IRQ_EN     = 2'b01;
    localparam logic [15:0] ICLR_MASK  = 16'h0002;
    localparam bit          GENLOCK_EN = 1'b0;
    logic [1:0] genlock_bits;
    // genlock_mode has no effect in this build.
    assign genlock_bits = genlock_mode & 2'b00;
`endif

    state_t          state_q, state_d;
    logic            gap_q, gap_d;
    logic [7:0]      idx_q, idx_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            error_q, error_d;
    logic [15:0]     irq_stat_q, irq_stat_d;
    logic [15:0]     mode_match_q, mode_match_d;
    logic [15:0]     uflow_q, uflow_d;
    logic            genlocked_q, genlocked_d;

    // Command decode for the current state (before gap/handshake gating).
    logic        cmd_rd, cmd_wr;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        issue, accept;

    // gap_q marks the mandatory idle cycle after each accepted command.
    assign issue  = (cmd_rd | cmd_wr) & ~gap_q;
    assign accept = issue & ~av.av_waitrequest;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gap_q        <= 1'b0;
            idx_q        <= 8'd0;
            poll_q       <= '0;
            stall_q      <= '0;
            error_q      <= 1'b0;
            irq_stat_q   <= 16'd0;
            mode_match_q <= 16'd0;
            uflow_q      <= 16'd0;
            genlocked_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            idx_q        <= idx_d;
            poll_q       <= poll_d;
            stall_q      <= stall_d;
            error_q      <= error_d;
            irq_stat_q   <= irq_stat_d;
            mode_match_q <= mode_match_d;
            uflow_q      <= uflow_d;
            genlocked_q  <= genlocked_d;
        end
    end

    // Next-state
    always_comb begin
        state_d      = state_q;
        gap_d        = accept;
        idx_d        = idx_q;
        poll_d       = poll_q;
        error_d      = error_q;
        irq_stat_d   = irq_stat_q;
        mode_match_d = mode_match_q;
        uflow_d      = uflow_q;
        genlocked_d  = genlocked_q;

        // Stall counter only runs while a write is held off; it saturates so
        // a stuck slave cannot wrap it back under the trip point.
        if (issue && cmd_wr && av.av_waitrequest) begin
            if (stall_q != STALL_MAX) stall_d = stall_q + 1'b1;
            else                      stall_d = stall_q;
            if (stall_q == STALL_TRIP) error_d = 1'b1;
        end else begin
            stall_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DIS;
                    error_d = 1'b0;
                end
            end
            S_DIS: begin
                if (accept) begin
                    state_d = S_LOAD;
                    idx_d   = 8'd0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (idx_q == IDX_LAST) state_d = S_ENA;
                    else                   idx_d   = idx_q + 8'd1;
                end
            end
            S_ENA: begin
                if (accept) begin
                    state_d = S_RUN;
                    poll_d  = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_DIS0;
                end else if (start) begin
                    state_d = S_DIS;
                    error_d = 1'b0;
                end else if (irq) begin
                    state_d = S_IRD;
                end else if (poll_q == POLL_LAST) begin
                    state_d = S_SRD;
                    poll_d  = '0;
                end else begin
                    poll_d = poll_q + 1'b1;
                end
            end
            S_DIS0: begin
                if (accept) state_d = S_IDLE;
            end
            S_IRD: begin
                if (accept) begin
                    state_d    = S_MRD;
                    irq_stat_d = av.av_readdata;
                end
            end
            S_MRD: begin
                if (accept) begin
                    state_d      = S_ICLR;
                    mode_match_d = av.av_readdata;
                end
            end
            S_ICLR: begin
                if (accept) state_d = S_RUN;
            end
            S_SRD: begin
                if (accept) begin
                    genlocked_d = GENLOCK_EN & av.av_readdata[3];
                    // bit2 is underflow_sticky
                    state_d = av.av_readdata[2] ? S_UCLR : S_RUN;
                end
            end
            S_UCLR: begin
                if (accept) begin
                    state_d = S_RUN;
                    if (uflow_q != 16'hFFFF) uflow_d = uflow_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        cmd_rd   = 1'b0;
        cmd_wr   = 1'b0;
        cmd_addr = 8'd0;
        cmd_data = 16'd0;
        case (state_q)
            S_DIS, S_DIS0: begin
                cmd_wr = 1'b1;
            end
            S_LOAD: begin
                cmd_wr   = 1'b1;
                cmd_addr = tbl_entry[23:16];
                cmd_data = tbl_entry[15:0];
            end
            S_ENA: begin
                cmd_wr   = 1'b1;
                cmd_data = {11'd0, genlock_bits, IRQ_EN, 1'b1};
            end
            S_IRD: begin
                cmd_rd   = 1'b1;
                cmd_addr = 8'd2;
            end
            S_MRD: begin
                cmd_rd   = 1'b1;
                cmd_addr = 8'd4;
            end
            S_ICLR: begin
                cmd_wr   = 1'b1;
                cmd_addr = 8'd2;
                cmd_data = irq_stat_q & ICLR_MASK;
            end
            S_SRD: begin
                cmd_rd   = 1'b1;
                cmd_addr = 8'd1;
            end
            S_UCLR: begin
                cmd_wr   = 1'b1;
                cmd_addr = 8'd1;
                cmd_data = 16'h0004;
            end
            default: begin
                cmd_rd = 1'b0;
            end
        endcase
    end

    assign av.av_read      = cmd_rd & ~gap_q;
    assign av.av_write     = cmd_wr & ~gap_q;
    assign av.av_address   = issue ? cmd_addr : 8'd0;
    assign av.av_writedata = (issue && cmd_wr) ? cmd_data : 16'd0;

    assign tbl_index       = idx_q;
    assign busy            = (state_q != S_IDLE) && (state_q != S_RUN);
    assign running         = (state_q == S_RUN) || (state_q == S_IRD) ||
                             (state_q == S_MRD) || (state_q == S_ICLR) ||
                             (state_q == S_SRD) || (state_q == S_UCLR);
    assign error           = error_q;
    assign underflow_count = uflow_q;
    assign mode_match      = mode_match_q;
    assign genlocked       = genlocked_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_alt_vipitc130_is2vid_ctrl_master.sv
// ---------------------------------------------------------------------------
// tb_alt_vipitc130_is2vid_ctrl_master
// Directed bench: programming sequence, write stall hold, stall timeout,
// interrupt service, status poll with underflow clear, stop, and reset in
// the middle of table loading.
// ---------------------------------------------------------------------------
module tb_alt_vipitc130_is2vid_ctrl_master;

    localparam int TBL_DEPTH   = 3;
    localparam int POLL_CYCLES = 200;
    localparam int TIMEOUT     = 8;

`ifdef ITC_CTRL_GENLOCK_EN
    localparam logic [15:0] EXP_ENA  = 16'h0017; // {2'b10, 2'b11, 1'b1}
    localparam logic [15:0] EXP_ICLR = 16'h0006;
    localparam logic        EXP_GL   = 1'b1;
`else
    localparam logic [15:0] EXP_ENA  = 16'h0003; // {2'b00, 2'b01, 1'b1}
    localparam logic [15:0] EXP_ICLR = 16'h0002;
    localparam logic        EXP_GL   = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        start, stop, irq;
    logic [1:0]  genlock_mode;
    logic [7:0]  tbl_index;
    logic [23:0] tbl_entry;
    logic        busy, running, error, genlocked;
    logic [15:0] underflow_count, mode_match;
    logic [3:0]  state_dbg;

    alt_vipitc130_is2vid_ctrl_master_if av_if ();

    alt_vipitc130_is2vid_ctrl_master #(
        .TBL_DEPTH  (TBL_DEPTH),
        .POLL_CYCLES(POLL_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .tbl_index      (tbl_index),
        .tbl_entry      (tbl_entry),
        .genlock_mode   (genlock_mode),
        .av             (av_if),
        .irq            (irq),
        .busy           (busy),
        .running        (running),
        .error          (error),
        .underflow_count(underflow_count),
        .mode_match     (mode_match),
        .genlocked      (genlocked),
        .state_dbg      (state_dbg)
    );

    // ---------------- table and slave model ----------------
    function automatic logic [23:0] tbl_fn(input logic [7:0] i);
        logic [15:0] d;
        d = 16'hA000 + ({8'd0, i} * 16'h0111);
        return {8'h10 + i, d};
    endfunction

    assign tbl_entry = tbl_fn(tbl_index);

    logic [15:0] rd_mem [0:255];
    int          stall_len;
    int          stall_seen;
    logic [7:0]  first_addr;
    logic [15:0] first_data;
    logic        both_seen;

    assign av_if.av_readdata    = rd_mem[av_if.av_address];
    assign av_if.av_waitrequest = av_if.av_write && (stall_seen < stall_len);

    logic [7:0]  w_addr_q[$];
    logic [15:0] w_data_q[$];
    int          w_hold_q[$];
    logic        w_stable_q[$];
    logic [7:0]  r_addr_q[$];

    initial begin
        stall_seen = 0;
        both_seen  = 1'b0;
        first_addr = 8'd0;
        first_data = 16'd0;
    end

    // Bus monitor: logs accepted commands and how long each write was held.
    always @(posedge clk) begin
        if (av_if.av_write && !av_if.av_waitrequest) begin
            w_addr_q.push_back(av_if.av_address);
            w_data_q.push_back(av_if.av_writedata);
            w_hold_q.push_back(stall_seen + 1);
            w_stable_q.push_back((stall_seen == 0) ||
                                 (av_if.av_address == first_addr && av_if.av_writedata == first_data));
        end
        if (av_if.av_read && !av_if.av_waitrequest) r_addr_q.push_back(av_if.av_address);
        if (av_if.av_read && av_if.av_write) both_seen <= 1'b1;
        if (av_if.av_write && av_if.av_waitrequest) begin
            if (stall_seen == 0) begin
                first_addr <= av_if.av_address;
                first_data <= av_if.av_writedata;
            end
            stall_seen <= stall_seen + 1;
        end else begin
            stall_seen <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    int tests;
    int failed;
    int w_ptr;
    logic [23:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        logic [23:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (w_ptr < w_addr_q.size())
                chk(tag, {8'd0, w_addr_q[w_ptr], w_data_q[w_ptr]}, {8'd0, e});
            else
                chk({tag, " missing"}, 32'(w_addr_q.size()), 32'(w_ptr + 1));
            w_ptr++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (w_addr_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " write count"}, 32'(w_addr_q.size() >= n), 32'd1);
    endtask

    task automatic wait_running(input int budget, input string tag);
        int k;
        k = 0;
        while (!(running && !busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " running"}, 32'(running), 32'd1);
    endtask

    task automatic wait_stall(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (stall_seen != n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " stall reached"}, 32'(stall_seen), 32'(n));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests = 0;
        failed = 0;
        w_ptr = 0;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        irq = 1'b0;
        genlock_mode = 2'b10;
        stall_len = 0;
        for (int i = 0; i < 256; i++) rd_mem[i] = 16'd0;

        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst running", 32'(running), 32'd0);
        chk("rst error", 32'(error), 32'd0);
        chk("rst av_write", 32'(av_if.av_write), 32'd0);
        chk("rst av_read", 32'(av_if.av_read), 32'd0);
        chk("rst underflow", 32'(underflow_count), 32'd0);
        chk("rst state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Programming; 2nd table write stalled 5 cycles; stray start dropped.
        pulse_start();
        wait_writes(2, 50, "prog a");
        stall_len = 5;
        pulse_start();
        wait_writes(3, 50, "prog b");
        stall_len = 0;
        wait_running(100, "prog");
        exp_q.push_back({8'h00, 16'h0000});
        for (int i = 0; i < TBL_DEPTH; i++) exp_q.push_back(tbl_fn(8'(i)));
        exp_q.push_back({8'h00, EXP_ENA});
        check_writes("prog write");
        chk("prog tbl1 hold", 32'(w_hold_q[1]), 32'd1);
        chk("stall hold", 32'(w_hold_q[2]), 32'd6);
        chk("stall stable", 32'(w_stable_q[2]), 32'd1);
        chk("stall error", 32'(error), 32'd0);
        chk("prog busy", 32'(busy), 32'd0);

        // Interrupt service
        rd_mem[2] = 16'h0006;
        rd_mem[4] = 16'h0005;
        irq = 1'b1;
        wait_writes(6, 50, "irq");
        irq = 1'b0;
        chk("irq read count", 32'(r_addr_q.size()), 32'd2);
        chk("irq read0", 32'(r_addr_q[0]), 32'd2);
        chk("irq read1", 32'(r_addr_q[1]), 32'd4);
        exp_q.push_back({8'h02, EXP_ICLR});
        check_writes("iclr write");
        chk("mode_match", 32'(mode_match), 32'h0005);

        // Status poll with underflow set
        rd_mem[1] = 16'h000C;
        wait_writes(7, 400, "poll");
        rd_mem[1] = 16'h0000;
        chk("poll read addr", 32'(r_addr_q[2]), 32'd1);
        exp_q.push_back({8'h01, 16'h0004});
        check_writes("uclr write");
        chk("underflow_count", 32'(underflow_count), 32'd1);
        chk("genlocked", 32'(genlocked), 32'(EXP_GL));

        // Stop
        pulse_stop();
        wait_writes(8, 50, "stop");
        exp_q.push_back({8'h00, 16'h0000});
        check_writes("stop write");
        chk("stop running", 32'(running), 32'd0);
        chk("stop state", 32'(state_dbg), 32'd0);
        pulse_stop();
        repeat (3) @(negedge clk);
        chk("idle stop dropped", 32'(w_addr_q.size()), 32'd8);

        // Timeout: DIS write stalled TIMEOUT+2 cycles
        stall_len = TIMEOUT + 2;
        pulse_start();
        wait_stall(TIMEOUT - 1, 50, "to pre");
        chk("to error before", 32'(error), 32'd0);
        wait_stall(TIMEOUT, 50, "to at");
        chk("to error at", 32'(error), 32'd1);
        wait_writes(9, 50, "to");
        stall_len = 0;
        chk("to hold", 32'(w_hold_q[8]), 32'(TIMEOUT + 3));
        wait_running(100, "to");
        chk("to error sticky", 32'(error), 32'd1);
        exp_q.push_back({8'h00, 16'h0000});
        for (int i = 0; i < TBL_DEPTH; i++) exp_q.push_back(tbl_fn(8'(i)));
        exp_q.push_back({8'h00, EXP_ENA});
        check_writes("to write");

        // Restart from RUN clears error
        pulse_start();
        chk("restart error", 32'(error), 32'd0);
        chk("restart busy", 32'(busy), 32'd1);

        // Reset in the middle of a table write
        wait_writes(15, 50, "rst mid");
        @(negedge clk);
        chk("pre-rst av_write", 32'(av_if.av_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid rst av_write", 32'(av_if.av_write), 32'd0);
        chk("mid rst av_read", 32'(av_if.av_read), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst tbl_index", 32'(tbl_index), 32'd0);
        chk("mid rst underflow", 32'(underflow_count), 32'd0);
        chk("mid rst mode_match", 32'(mode_match), 32'd0);
        chk("mid rst genlocked", 32'(genlocked), 32'd0);
        chk("mid rst state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post rst writes", 32'(w_addr_q.size()), 32'd15);
        chk("rd/wr exclusive", 32'(both_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
